// File: rtl/uart_mmio_pkg.sv
// Shared constants for the memory-mapped console transmitter:
// register map, STATUS layout, store encodings and FSM state codes.
package uart_mmio_pkg;

    localparam logic [31:0] TXDATA_OFS = 32'h0;
    localparam logic [31:0] STATUS_OFS = 32'h4;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    function automatic logic is_store_funct3(input logic [2:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and a combinational head read.
// A push on a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking so every register here sees pre-edge values of the others.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage has no reset; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 console transmitter: byte stores to TXDATA are queued and
// serialised on tx; STATUS exposes busy/full/empty/overflow/count for software.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0004_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [2:0]  funct3,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic        tx,
    output logic        tx_busy,
    output logic        char_valid,
    output logic [7:0]  char_data
);
    import uart_mmio_pkg::*;

    localparam int            CW          = $clog2(CLKS_PER_BIT);
    localparam int            AW          = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          overflow;

    logic          push_req;
    logic          ovf_set;
    logic          ovf_clr;
    logic          pop;
    logic          bit_done;
    logic [7:0]    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;
    logic          unused_wr_bits;

    assign unused_wr_bits = ^wr_data[31:8];

    assign push_req = wr_en && (wr_addr == BASE_ADDR + TXDATA_OFS) && is_store_funct3(funct3);
    assign ovf_clr  = wr_en && (wr_addr == BASE_ADDR + STATUS_OFS) && wr_data[STAT_OVF];
    assign ovf_set  = push_req && fifo_full && !pop;

    assign bit_done = (baud_cnt == '0);
    assign tx_busy  = (state != ST_IDLE);
    // A new frame starts from IDLE or straight out of a finished STOP bit.
    assign pop      = !fifo_empty &&
                      ((state == ST_IDLE) || ((state == ST_STOP) && bit_done));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (wr_data[7:0]),
        .pop       (pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            tx         <= 1'b1;
            char_valid <= 1'b0;
            char_data  <= '0;
        end else begin
            char_valid <= 1'b0;
            if (pop) begin
                shreg      <= head;
                char_valid <= 1'b1;
                char_data  <= head;
                tx         <= 1'b0;
                baud_cnt   <= BAUD_RELOAD;
                state      <= ST_START;
            end else begin
                if (state != ST_IDLE) baud_cnt <= bit_done ? BAUD_RELOAD : baud_cnt - CW'(1);
                case (state)
                    ST_START: if (bit_done) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                    end
                    ST_DATA: if (bit_done) begin
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end
                    ST_STOP: if (bit_done) state <= ST_IDLE;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        // NOTE: default every output first so no path through the block infers a latch.
        rd_data = '0;
        rd_hit  = 1'b0;
        if (rd_addr == BASE_ADDR + TXDATA_OFS) begin
            rd_hit = 1'b1;
        end else if (rd_addr == BASE_ADDR + STATUS_OFS) begin
            rd_hit                       = 1'b1;
            rd_data[STAT_BUSY]           = tx_busy;
            rd_data[STAT_FULL]           = fifo_full;
            rd_data[STAT_EMPTY]          = fifo_empty;
            rd_data[STAT_OVF]            = overflow;
            rd_data[STAT_CNT_LSB +: 8]   = 8'(fifo_count);
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=8;
// inputs change and outputs are sampled on the falling clock edge.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0004_0000;
    localparam logic [31:0] STAT = 32'h0004_0004;
    localparam int          CPB  = 4;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  funct3;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic        tx;
    logic        tx_busy;
    logic        char_valid;
    logic [7:0]  char_data;

    int n_checks = 0;
    int n_passed = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .funct3     (funct3),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_hit     (rd_hit),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .char_valid (char_valid),
        .char_data  (char_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        funct3  = f3;
        @(negedge clk);
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        funct3  = '0;
    endtask

    task automatic check_read(input string tag, input logic [31:0] addr,
                              input logic [31:0] exp_data, input logic exp_hit);
        rd_addr = addr;
        #1;
        check({tag, "_data"}, rd_data, exp_data);
        check({tag, "_hit"}, rd_hit, exp_hit);
    endtask

    // Called at the falling edge right after the pop; ends on the frame's last sample.
    task automatic receive_frame(input logic [7:0] b, input string tag);
        logic [9:0] frame;
        logic [3:0] seen;
        logic       busy_all;
        int         pulses;
        frame    = {1'b1, b, 1'b0};
        busy_all = 1'b1;
        pulses   = 0;
        check({tag, "_data"}, char_data, b);
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < CPB; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                seen[c]  = tx;
                busy_all = busy_all & tx_busy;
                if (char_valid) pulses++;
            end
            check($sformatf("%s_bit%0d", tag, k), seen, {4{frame[k]}});
        end
        check({tag, "_busy"}, busy_all, 1);
        check({tag, "_pulses"}, pulses, 1);
    endtask

    task automatic wait_char(input int bound, input string tag);
        int n = 0;
        while (!char_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_seen"}, char_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           pulses;
        logic [7:0]   drain [8];
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        funct3  = '0;
        rd_addr = '0;
        repeat (2) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_cv", char_valid, 0);
        check("rst_cd", char_data, 0);
        reset = 1'b1;
        @(negedge clk);

        // Register reads when idle and empty
        check_read("t4_status", STAT, 32'h0000_0004, 1'b1);
        check_read("t4_txdata", BASE, 32'h0, 1'b1);
        check_read("t4_below", 32'h0003_FFFC, 32'h0, 1'b0);

        // Test 1: single SB, one-cycle latency to pop
        store(BASE, 32'h0000_0041, 3'b000);
        check("t1_no_early_cv", char_valid, 0);
        check("t1_tx_idle", tx, 1);
        check_read("t1_queued", STAT, 32'h0000_0100, 1'b1);
        @(negedge clk);
        check("t1_cv", char_valid, 1);
        receive_frame(8'h41, "t1");
        @(negedge clk);
        check("t1_busy_end", tx_busy, 0);
        check("t1_tx_end", tx, 1);

        // Unsupported store width at TXDATA is ignored
        store(BASE, 32'h0000_0077, 3'b011);
        repeat (3) @(negedge clk);
        check("bad_f3_busy", tx_busy, 0);
        check_read("bad_f3_status", STAT, 32'h0000_0004, 1'b1);

        // Test 2: SW then SH back-to-back, stray write to BASE+8
        store(BASE, 32'h1234_5655, 3'b010);
        store(BASE, 32'h0000_FF48, 3'b001);
        check("t2a_cv", char_valid, 1);
        fork
            store(BASE + 32'h8, 32'h0000_0099, 3'b010);
            receive_frame(8'h55, "t2a");
        join
        @(negedge clk);
        check("t2b_cv", char_valid, 1);
        receive_frame(8'h48, "t2b");
        @(negedge clk);
        check("t2_busy_end", tx_busy, 0);
        check_read("t2_status", STAT, 32'h0000_0004, 1'b1);

        // Test 3: overflow with 10 consecutive pushes, then W1C
        for (int i = 0; i < 10; i++) store(BASE, 32'h60 + 32'(i), 3'b000);
        check_read("t3_full_ovf", STAT, 32'h0000_080B, 1'b1);
        store(STAT, 32'h0000_0008, 3'b010);
        check_read("t3_ovf_clr", STAT, 32'h0000_0803, 1'b1);

        // Test 6: push on a full FIFO on the STOP-end pop edge
        repeat (30) @(negedge clk);
        store(BASE, 32'h0000_00A5, 3'b000);
        check("t6_cv", char_valid, 1);
        check("t6_cd", char_data, 8'h61);
        check_read("t6_status", STAT, 32'h0000_0803, 1'b1);

        drain = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'hA5};
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            wait_char(50, $sformatf("t3_drain%0d", j));
            check($sformatf("t3_drain%0d_data", j), char_data, drain[j]);
        end
        repeat (45) @(negedge clk);
        check("t3_busy_end", tx_busy, 0);
        check_read("t3_status_end", STAT, 32'h0000_0004, 1'b1);

        // Test 5: reset during DATA bit 3 with bytes still queued
        store(BASE, 32'h0000_00F0, 3'b000);
        store(BASE, 32'h0000_0011, 3'b000);
        store(BASE, 32'h0000_0022, 3'b000);
        repeat (16) @(negedge clk);
        check("t5_bit3_tx", tx, 0);
        check_read("t5_pre_status", STAT, 32'h0000_0201, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_tx", tx, 1);
        check("t5_rst_busy", tx_busy, 0);
        check("t5_rst_cv", char_valid, 0);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (char_valid) pulses++;
        end
        check("t5_no_cv", pulses, 0);
        check("t5_tx_idle", tx, 1);
        check_read("t5_status", STAT, 32'h0000_0004, 1'b1);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
